// File: rtl/quat_serial_adder_pkg.sv
// quat_serial_adder_pkg: shared FSM state encoding and digit width for the serial base-4 adder
package quat_serial_adder_pkg;
  localparam int DIGIT_W = 2;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/quat_digit_adder.sv
// quat_digit_adder: one base-4 digit full adder; a_i/b_i/c_i in, s_o digit and c_o carry out
module quat_digit_adder
  import quat_serial_adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               c_i,
  output logic [DIGIT_W-1:0] s_o,
  output logic               c_o
);
  logic [DIGIT_W:0] d;
  assign d = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_W{1'b0}}, c_i};
  assign s_o = d[DIGIT_W-1:0];
  assign c_o = d[DIGIT_W];
endmodule

// File: rtl/quat_serial_adder.sv
// quat_serial_adder: digit-serial base-4 add/sub; start/sub/a/b in, busy/done pulse/sum/cout out
module quat_serial_adder
  import quat_serial_adder_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sub,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout
);
  localparam int W = DIGIT_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, sub_q, sub_d, cout_q, cout_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
  logic c_dig;
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IW'(i)) begin
        a_dig = a_q[DIGIT_W*i +: DIGIT_W];
        b_dig = b_q[DIGIT_W*i +: DIGIT_W];
      end
  end
  quat_digit_adder u_dig (
    .a_i(a_dig),
    .b_i(sub_q ? ~b_dig : b_dig),
    .c_i(carry_q),
    .s_o(s_dig),
    .c_o(c_dig)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub;
          sum_d   = '0;
          state_d = S_RUN;
        end
      S_RUN: begin
        for (int i = 0; i < DIGITS; i++)
          if (idx_q == IW'(i)) sum_d[DIGIT_W*i +: DIGIT_W] = s_dig;
        carry_d = c_dig;
        if (idx_q == IW'(DIGITS - 1)) begin
          cout_d  = c_dig;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_quat_serial_adder.sv
// tb_quat_serial_adder: directed table, corner sequences and random ops against DIGITS=4 and DIGITS=8 instances
module tb_quat_serial_adder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic start4 = 1'b0, sub4 = 1'b0, busy4, done4, cout4;
  logic [7:0] a4 = '0, b4 = '0, sum4;
  logic start8 = 1'b0, sub8 = 1'b0, busy8, done8, cout8;
  logic [15:0] a8 = '0, b8 = '0, sum8;
  quat_serial_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );
  quat_serial_adder #(.DIGITS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] e;
    logic       c;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [16:0] ref_op(input int digits, input logic [15:0] x, input logic [15:0] y, input logic s);
    longint m, r;
    logic [31:0] t;
    m = longint'(1) << (2 * digits);
    r = s ? (longint'(x) - longint'(y) + m) % m : (longint'(x) + longint'(y)) % m;
    t = 32'(r);
    return {s ? x >= y : (longint'(x) + longint'(y)) >= m, t[15:0]};
  endfunction
  task automatic run_op(input bit w8, input logic [15:0] x, input logic [15:0] y, input logic s,
                        output logic [15:0] r, output logic c, output int lat);
    if (w8) begin
      a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
    end else begin
      a4 = x[7:0]; b4 = y[7:0]; sub4 = s; start4 = 1'b1;
    end
    step;
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = ~a4;
    a8 = ~a8;
    lat = 1;
    while (!(w8 ? done8 : done4) && lat < 40) begin
      step;
      lat++;
    end
    r = w8 ? sum8 : {8'h00, sum4};
    c = w8 ? cout8 : cout4;
  endtask
  initial begin
    logic [15:0] r, x, y;
    logic c, s;
    logic [16:0] e;
    int lat, nd;
    tv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[1] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0};
    tv[2] = '{8'h6C, 8'h1B, 1'b1, 8'h51, 1'b1};
    tv[3] = '{8'h6C, 8'h1B, 1'b0, 8'h87, 1'b0};
    tv[4] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    tv[5] = '{8'h37, 8'h80, 1'b1, 8'hB7, 1'b0};
    tv[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tv[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
    tv[8] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
    start4 = 1'b1;
    repeat (3) step;
    chk("reset_busy", 32'(busy4), 32'd0);
    chk("reset_done", 32'(done4), 32'd0);
    chk("reset_sum", 32'(sum4), 32'd0);
    chk("reset_cout", 32'(cout4), 32'd0);
    start4 = 1'b0;
    reset = 1'b0;
    step;
    for (int i = 0; i < 9; i++) begin
      run_op(1'b0, {8'h00, tv[i].a}, {8'h00, tv[i].b}, tv[i].s, r, c, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_sum", i), 32'(r), 32'(tv[i].e));
      chk($sformatf("vec%0d_cout", i), 32'(c), 32'(tv[i].c));
      chk($sformatf("vec%0d_busy_done", i), 32'(busy4), 32'd1);
      step;
      chk($sformatf("vec%0d_done_pulse", i), 32'({done4, busy4}), 32'd0);
      chk($sformatf("vec%0d_hold", i), 32'({cout4, sum4}), 32'({tv[i].c, tv[i].e}));
    end
    a4 = 8'h12; b4 = 8'h77; sub4 = 1'b0;
    repeat (4) step;
    chk("idle_hold", 32'({busy4, cout4, sum4}), 32'({1'b0, 1'b1, 8'h00}));
    a4 = 8'h12; b4 = 8'h34; sub4 = 1'b0; start4 = 1'b1;
    step;
    a4 = 8'hF0; b4 = 8'h0F; sub4 = 1'b1;
    lat = 1;
    while (!done4 && lat < 40) begin step; lat++; end
    chk("b2b_first_latency", 32'(lat), 32'd5);
    chk("b2b_first_result", 32'({cout4, sum4}), 32'({1'b0, 8'h46}));
    step;
    chk("b2b_idle_gap", 32'({busy4, done4}), 32'd0);
    lat = 1;
    while (!done4 && lat < 40) begin step; lat++; end
    chk("b2b_second_latency", 32'(lat), 32'd6);
    chk("b2b_second_result", 32'({cout4, sum4}), 32'({1'b1, 8'hE1}));
    start4 = 1'b0;
    step;
    a4 = 8'h6C; b4 = 8'h1B; sub4 = 1'b1; start4 = 1'b1;
    step;
    start4 = 1'b0;
    step;
    step;
    chk("abort_busy_before", 32'(busy4), 32'd1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_state", 32'({busy4, done4, cout4, sum4}), 32'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4 || busy4) nd++;
      step;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run_op(1'b0, 16'h006C, 16'h001B, 1'b0, r, c, lat);
    chk("after_abort_latency", 32'(lat), 32'd5);
    chk("after_abort_result", 32'({c, r}), 32'({1'b0, 16'h0087}));
    step;
    for (int i = 0; i < 1000; i++) begin
      bit w8;
      w8 = (i % 2) == 1;
      x = 16'($urandom);
      y = 16'($urandom);
      s = 1'($urandom);
      if (!w8) begin
        x[15:8] = 8'h00;
        y[15:8] = 8'h00;
      end
      e = ref_op(w8 ? 8 : 4, x, y, s);
      run_op(w8, x, y, s, r, c, lat);
      chk($sformatf("rnd%0d_d%0d_latency", i, w8 ? 8 : 4), 32'(lat), w8 ? 32'd9 : 32'd5);
      chk($sformatf("rnd%0d_d%0d_%0h_%s_%0h", i, w8 ? 8 : 4, x, s ? "sub" : "add", y), 32'({c, r}), 32'(e));
      step;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
